// File: rtl/normalize32_if.sv
// normalize32_if: start/done request bundle for the 32-bit normalizer.
//
// Signals
//   start  requester -> normalizer  begin a search (taken only while busy=0)
//   d      requester -> normalizer  32-bit operand, captured with start
//   lnr    requester -> normalizer  1 = left normalize, 0 = right normalize
//   busy   normalizer -> requester  search in progress
//   done   normalizer -> requester  one-cycle completion pulse
//   y      normalizer -> requester  normalized value
//   s      normalizer -> requester  shift count, 0..32, zero-extended
//   zero   normalizer -> requester  captured operand was zero
//
// Handshake: a request is accepted on the rising clock edge where start=1
// and busy=0; d and lnr are captured on that same edge and ignored
// afterwards. done pulses for exactly one cycle when the result lands, and
// y/s/zero hold that result until the next completion or reset. start while
// busy=1 is dropped, never queued.
interface normalize32_if;
  logic        start;
  logic [31:0] d;
  logic        lnr;
  logic        busy;
  logic        done;
  logic [31:0] y;
  logic [31:0] s;
  logic        zero;

  modport master (
    output start, d, lnr,
    input  busy, done, y, s, zero
  );

  modport slave (
    input  start, d, lnr,
    output busy, done, y, s, zero
  );
endinterface

// File: rtl/normalize32_seq.sv
// normalize32_seq: iterative 32-bit normalizer (inverse of a barrel shifter).
//
// Left mode finds the shift s that moves the leading 1 of d up to bit 31;
// right mode finds the s that moves the trailing 1 of d down to bit 0.
// The search is binary: steps of 16, 8, 4, 2, 1 bits, one per clock, so the
// result is ready a fixed 5 cycles after the accepting edge for any operand.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        normalize32_if slave (start/d/lnr in, busy/done/y/s/zero out)
//   dbg_state  1 while the FSM is in SEARCH, 0 in IDLE
module normalize32_seq (
  input  logic          clk,
  input  logic          rst_n,
  normalize32_if.slave  bus,
  output logic          dbg_state
);

  typedef enum logic {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] w_q;       // working value being shifted toward the edge
  logic [5:0]  c_q;       // accumulated shift count
  logic [2:0]  k_q;       // current step exponent, step size is 2^k
  logic        mode_q;    // 1 = left, 0 = right
  logic        zflag_q;   // captured operand was zero
  logic        busy_q;
  logic        done_q;
  logic [31:0] y_q;
  logic [5:0]  s_q;
  logic        zero_q;

  logic [5:0]  step_n;
  logic        left_hit;
  logic        right_hit;
  logic [31:0] w_next;
  logic [5:0]  c_next;

  // The top (left) or bottom (right) step_n bits of w are tested; if they
  // are all zero the leading/trailing 1 lies further in, so shift past them.
  assign step_n    = 6'd1 << k_q;
  assign left_hit  = (w_q & ~(32'hFFFF_FFFF >> step_n)) == 32'd0;
  assign right_hit = (w_q & ~(32'hFFFF_FFFF << step_n)) == 32'd0;

  always_comb begin
    w_next = w_q;
    c_next = c_q;
    if (mode_q && left_hit) begin
      w_next = w_q << step_n;
      c_next = c_q + step_n;
    end else if (!mode_q && right_hit) begin
      w_next = w_q >> step_n;
      c_next = c_q + step_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      w_q     <= 32'd0;
      c_q     <= 6'd0;
      k_q     <= 3'd0;
      mode_q  <= 1'b0;
      zflag_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= 32'd0;
      s_q     <= 6'd0;
      zero_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            w_q     <= bus.d;
            c_q     <= 6'd0;
            k_q     <= 3'd4;
            mode_q  <= bus.lnr;
            zflag_q <= (bus.d == 32'd0);
            busy_q  <= 1'b1;
            state   <= SEARCH;
          end
        end
        SEARCH: begin
          w_q <= w_next;
          c_q <= c_next;
          k_q <= k_q - 3'd1;
          if (k_q == 3'd0) begin
            // A zero operand walks every step and ends at c=31; the shifter
            // needs 32 to return zero, so the count is forced.
            y_q    <= w_next;
            s_q    <= zflag_q ? 6'd32 : c_next;
            zero_q <= zflag_q;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.y     = y_q;
  assign bus.s     = {26'd0, s_q};
  assign bus.zero  = zero_q;
  assign dbg_state = (state == SEARCH);

endmodule

// File: tb/tb_normalize32_seq.sv
module tb_normalize32_seq;

  logic clk;
  logic rst_n;
  logic dbg_state;
  int   n_checks;
  int   n_pass;

  normalize32_if bus ();

  normalize32_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver ----------------
  // Issues one request and waits for done. Inputs are scrambled after the
  // accepting edge. lat is cycles from the accepting edge to done, -1 on
  // timeout. Returns at the negedge where done is high.
  task automatic run_op(input logic [31:0] dv, input logic lv,
                        output logic [31:0] yo, output logic [31:0] so,
                        output logic zo, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.d     = dv;
    bus.lnr   = lv;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.start = 1'b0;
        bus.d     = $urandom();
        bus.lnr   = 1'($urandom_range(0, 1));
      end
      if (bus.done) begin
        lat = i - 1;
        break;
      end
    end
    yo = bus.y;
    so = bus.s;
    zo = bus.zero;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.d     = 32'd0;
    bus.lnr   = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if ({bus.busy, bus.done, bus.zero, dbg_state} !== 4'b0)
      $display("FAIL reset_flags: got %b want 0000", {bus.busy, bus.done, bus.zero, dbg_state});
    else n_pass++;
    n_checks++; if (bus.y !== 32'd0) $display("FAIL reset_y: got %h want 0", bus.y); else n_pass++;
    n_checks++; if (bus.s !== 32'd0) $display("FAIL reset_s: got %h want 0", bus.s); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_single_one();
    logic [31:0] y, s; logic z; int lat;
    run_op(32'h0000_0001, 1'b1, y, s, z, lat);
    n_checks++; if (lat !== 5) $display("FAIL t1_latency: got %0d want 5", lat); else n_pass++;
    n_checks++; if (s !== 32'd31) $display("FAIL t1_s: got %0d want 31", s); else n_pass++;
    n_checks++; if (y !== 32'h8000_0000) $display("FAIL t1_y: got %h want 80000000", y); else n_pass++;
    n_checks++; if (z !== 1'b0) $display("FAIL t1_zero: got %b want 0", z); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.done !== 1'b0) $display("FAIL t1_done_width: got %b want 0", bus.done); else n_pass++;
    n_checks++; if (bus.y !== 32'h8000_0000) $display("FAIL t1_y_hold: got %h want 80000000", bus.y); else n_pass++;
  endtask

  task automatic test_msb();
    logic [31:0] y, s; logic z; int lat;
    run_op(32'h8000_0000, 1'b1, y, s, z, lat);
    n_checks++; if (s !== 32'd0) $display("FAIL t2_left_s: got %0d want 0", s); else n_pass++;
    n_checks++; if (y !== 32'h8000_0000) $display("FAIL t2_left_y: got %h want 80000000", y); else n_pass++;
    run_op(32'h8000_0000, 1'b0, y, s, z, lat);
    n_checks++; if (s !== 32'd31) $display("FAIL t2_right_s: got %0d want 31", s); else n_pass++;
    n_checks++; if (y !== 32'h0000_0001) $display("FAIL t2_right_y: got %h want 00000001", y); else n_pass++;
  endtask

  task automatic test_mixed();
    logic [31:0] y, s; logic z; int lat;
    run_op(32'h0001_2340, 1'b1, y, s, z, lat);
    n_checks++; if (s !== 32'd15) $display("FAIL t3_left_s: got %0d want 15", s); else n_pass++;
    n_checks++; if (y !== 32'h91A0_0000) $display("FAIL t3_left_y: got %h want 91a00000", y); else n_pass++;
    run_op(32'h0001_2340, 1'b0, y, s, z, lat);
    n_checks++; if (s !== 32'd6) $display("FAIL t3_right_s: got %0d want 6", s); else n_pass++;
    n_checks++; if (y !== 32'h0000_048D) $display("FAIL t3_right_y: got %h want 0000048d", y); else n_pass++;
  endtask

  task automatic test_zero();
    logic [31:0] y, s; logic z; int lat;
    for (int m = 0; m < 2; m++) begin
      run_op(32'd0, 1'(m), y, s, z, lat);
      n_checks++; if (lat !== 5) $display("FAIL t4_latency lnr=%0d: got %0d want 5", m, lat); else n_pass++;
      n_checks++; if ({y, s, z} !== {32'd0, 32'd32, 1'b1})
        $display("FAIL t4_result lnr=%0d: got y=%h s=%0d z=%b want y=0 s=32 z=1", m, y, s, z);
      else n_pass++;
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] y, s; logic z; int lat;
    run_op(32'h0000_0001, 1'b1, y, s, z, lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.d     = 32'h00F0_0000;
    bus.lnr   = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = i - 1;
        break;
      end
      if (i == 3) begin
        n_checks++; if ({bus.busy, dbg_state} !== 2'b11)
          $display("FAIL t5_busy_mid: got %b want 11", {bus.busy, dbg_state});
        else n_pass++;
        n_checks++; if ({bus.y, bus.s} !== {32'h8000_0000, 32'd31})
          $display("FAIL t5_hold_mid: got y=%h s=%0d want y=80000000 s=31", bus.y, bus.s);
        else n_pass++;
      end
      bus.start = (i >= 2 && i <= 4);
      bus.d     = (i >= 2 && i <= 4) ? 32'hFFFF_FFFF : 32'h00F0_0000;
      bus.lnr   = (i >= 2 && i <= 4) ? 1'b0 : 1'b1;
    end
    n_checks++; if (lat !== 5) $display("FAIL t5_ignore_latency: got %0d want 5", lat); else n_pass++;
    n_checks++; if ({bus.y, bus.s} !== {32'hF000_0000, 32'd8})
      $display("FAIL t5_ignore_result: got y=%h s=%0d want y=f0000000 s=8", bus.y, bus.s);
    else n_pass++;
  endtask

  task automatic test_start_in_done();
    logic [31:0] y, s; logic z; int lat;
    run_op(32'h0001_2340, 1'b0, y, s, z, lat);
    bus.start = 1'b1;
    bus.d     = 32'h8000_0000;
    bus.lnr   = 1'b0;
    @(negedge clk);
    n_checks++; if ({bus.busy, bus.done} !== 2'b10)
      $display("FAIL t5_done_accept: got busy,done=%b want 10", {bus.busy, bus.done});
    else n_pass++;
    n_checks++; if ({bus.y, bus.s} !== {32'h0000_048D, 32'd6})
      $display("FAIL t5_done_hold: got y=%h s=%0d want y=0000048d s=6", bus.y, bus.s);
    else n_pass++;
    bus.start = 1'b0;
    lat = -1;
    for (int i = 2; i <= 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = i - 1;
        break;
      end
    end
    n_checks++; if (lat !== 5) $display("FAIL t5_done_latency: got %0d want 5", lat); else n_pass++;
    n_checks++; if ({bus.y, bus.s} !== {32'h0000_0001, 32'd31})
      $display("FAIL t5_done_result: got y=%h s=%0d want y=00000001 s=31", bus.y, bus.s);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] y, s; logic z; int lat; int pulses;
    @(negedge clk);
    bus.start = 1'b1;
    bus.d     = 32'h0000_FFFF;
    bus.lnr   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.busy, bus.done, bus.zero, dbg_state} !== 4'b0)
      $display("FAIL t6_abort_flags: got %b want 0000", {bus.busy, bus.done, bus.zero, dbg_state});
    else n_pass++;
    n_checks++; if ({bus.y, bus.s} !== 64'd0)
      $display("FAIL t6_abort_outputs: got y=%h s=%0d want 0 0", bus.y, bus.s);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    n_checks++; if (pulses !== 0) $display("FAIL t6_no_done: got %0d pulses want 0", pulses); else n_pass++;
    run_op(32'h0000_0100, 1'b1, y, s, z, lat);
    n_checks++; if ({y, s, z} !== {32'h8000_0000, 32'd23, 1'b0} || lat !== 5)
      $display("FAIL t6_after_reset: got y=%h s=%0d z=%b lat=%0d want y=80000000 s=23 z=0 lat=5", y, s, z, lat);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int first, second, pulses;
    @(negedge clk);
    bus.start = 1'b1;
    bus.d     = 32'h0000_0003;
    bus.lnr   = 1'b0;
    first = -1; second = -1; pulses = 0;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (bus.done) begin
        pulses++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    n_checks++; if (pulses !== 3) $display("FAIL b2b_pulses: got %0d want 3", pulses); else n_pass++;
    n_checks++; if (second - first !== 6) $display("FAIL b2b_period: got %0d want 6", second - first); else n_pass++;
    n_checks++; if ({bus.y, bus.s} !== {32'h0000_0003, 32'd0})
      $display("FAIL b2b_result: got y=%h s=%0d want y=00000003 s=0", bus.y, bus.s);
    else n_pass++;
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.busy && !bus.done) break;
    end
  endtask

  task automatic test_random();
    logic [31:0] y, s, dv, ey, es; logic z, lv; int lat; int bad;
    bad = 0;
    for (int n = 0; n < 1500; n++) begin
      dv = $urandom();
      case ($urandom_range(0, 3))
        0: dv = dv >> $urandom_range(0, 31);
        1: dv = dv << $urandom_range(0, 31);
        2: dv = (n % 50 == 0) ? 32'd0 : (32'd1 << $urandom_range(0, 31));
        default: ;
      endcase
      lv = 1'($urandom_range(0, 1));
      es = 32'd32;
      if (lv) begin
        for (int b = 31; b >= 0; b--) if (dv[b]) begin es = 32'(31 - b); break; end
      end else begin
        for (int b = 0; b < 32; b++) if (dv[b]) begin es = 32'(b); break; end
      end
      ey = (dv == 32'd0) ? 32'd0 : (lv ? dv << es : dv >> es);
      run_op(dv, lv, y, s, z, lat);
      n_checks++;
      if ({y, s, z} !== {ey, es, dv == 32'd0} || lat !== 5) begin
        if (bad < 10)
          $display("FAIL rand d=%h lnr=%b: got y=%h s=%0d z=%b lat=%0d want y=%h s=%0d z=%b lat=5",
                   dv, lv, y, s, z, lat, ey, es, dv == 32'd0);
        bad++;
      end else n_pass++;
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_single_one();
    test_msb();
    test_mixed();
    test_zero();
    test_ignore_start();
    test_start_in_done();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
